// File: rtl/load_store_unit.sv
// Load/store unit: takes one memory op from the pipeline, runs a req/ack
// handshake with data memory, returns load data as a one-cycle writeback
// pulse, and aborts with a one-cycle err pulse if memory never acknowledges.
//
// Ports:
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   op_valid/op_store     pipeline op request, 1 = store / 0 = load
//   op_addr/op_wdata      address and store data from the register file
//   op_dest               load destination register index
//   stall                 unit busy, pipeline holds its op
//   mem_req/mem_we        memory request and write enable
//   mem_addr/mem_wdata    memory address and write data
//   mem_ack/mem_rdata     memory completion pulse and read data
//   wb_write/wb_reg/wb_data  register-file writeback (one-cycle strobe)
//   err                   timeout abort pulse
module load_store_unit #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned REG_W   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  input  logic              op_store,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic [DATA_W-1:0] op_wdata,
  input  logic [REG_W-1:0]  op_dest,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_write,
  output logic [REG_W-1:0]  wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              err
);

  // The counter holds the number of completed REQ cycles without ack, so the
  // abort fires at the end of the TIMEOUT-th REQ cycle.
  localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              stall_q, stall_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [REG_W-1:0]  dest_q, dest_d;
  logic              wb_write_q, wb_write_d;
  logic [REG_W-1:0]  wb_reg_q, wb_reg_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              err_q, err_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_d     = stall_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    dest_d      = dest_q;
    wb_write_d  = 1'b0;
    wb_reg_d    = wb_reg_q;
    wb_data_d   = wb_data_q;
    err_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        // mem_ack is deliberately ignored here
        if (op_valid) begin
          mem_we_d    = op_store;
          mem_addr_d  = op_addr;
          mem_wdata_d = op_wdata;
          dest_d      = op_dest;
          mem_req_d   = 1'b1;
          stall_d     = 1'b1;
          cnt_d       = '0;
          state_d     = StReq;
        end
      end
      StReq: begin
        // Ack takes priority over a coincident timeout.
        if (mem_ack) begin
          mem_req_d = 1'b0;
          stall_d   = 1'b0;
          state_d   = StIdle;
          if (!mem_we_q) begin
            wb_write_d = 1'b1;
            wb_reg_d   = dest_q;
            wb_data_d  = mem_rdata;
          end
        end else if (cnt_q == CntLast) begin
          mem_req_d = 1'b0;
          stall_d   = 1'b0;
          err_d     = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      stall_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      dest_q      <= '0;
      wb_write_q  <= 1'b0;
      wb_reg_q    <= '0;
      wb_data_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_q     <= stall_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      dest_q      <= dest_d;
      wb_write_q  <= wb_write_d;
      wb_reg_q    <= wb_reg_d;
      wb_data_q   <= wb_data_d;
      err_q       <= err_d;
    end
  end

  assign stall     = stall_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_write  = wb_write_q;
  assign wb_reg    = wb_reg_q;
  assign wb_data   = wb_data_q;
  assign err       = err_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-side counterpart to the register file's store-data and address outputs.
- Accepts one load or store per request from the pipeline and runs a req/ack handshake with data memory.
- For loads, returns the result to the register-file write port as a one-cycle writeback.
- Stalls the pipeline while a request is outstanding, and aborts with an error pulse if memory never acknowledges.

Parameters:
- DATA_W, 16, data width of registers and memory words
- ADDR_W, 16, memory address width
- REG_W, 4, destination register index width
- TIMEOUT, 255, max REQ cycles without ack before abort (legal range 1..2^16-1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- op_valid  in  1  pipeline presents a memory op
- op_store  in  1  1 = store, 0 = load
- op_addr  in  ADDR_W  memory address (register-file address output)
- op_wdata  in  DATA_W  store data (register-file store-data output)
- op_dest  in  REG_W  load destination register
- stall  out  1  unit busy; pipeline must hold its op stable
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  request address
- mem_wdata  out  DATA_W  write data
- mem_ack  in  1  memory completion, one-cycle pulse
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- wb_write  out  1  register-file write strobe, one-cycle pulse
- wb_reg  out  REG_W  writeback register index
- wb_data  out  DATA_W  writeback data
- err  out  1  timeout abort, one-cycle pulse

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n), sampled only on the rising clk edge.
- Reset (rst_n=0 at an edge):
  - state=IDLE, timeout counter=0.
  - All outputs registered 0: stall, mem_req, mem_we, mem_addr, mem_wdata, wb_write, wb_reg, wb_data, err.
  - Reset mid-REQ drops mem_req at that edge; no writeback and no err follow.
- FSM states: IDLE, REQ.
- IDLE:
  - op_valid=1 at an edge → latch op_store/op_addr/op_wdata/op_dest into mem_we/mem_addr/mem_wdata/pending dest.
  - Same edge: set mem_req=1 and stall=1, clear counter, go to REQ.
  - mem_ack in IDLE is ignored.
- REQ:
  - mem_req, mem_we, mem_addr and mem_wdata are held constant.
  - op_valid is ignored; the pipeline keeps the same op presented because stall=1.
  - Counter increments each REQ cycle without ack.
- Ack (mem_ack=1 in REQ at an edge):
  - mem_req=0, stall=0, go to IDLE.
  - Load: wb_write=1 for exactly the next cycle, with wb_reg=pending dest and wb_data=mem_rdata sampled at the ack edge.
  - Store: no writeback.
- Timeout:
  - If the counter reaches TIMEOUT with mem_ack=0: mem_req=0, stall=0, err=1 for one cycle, no writeback, go to IDLE.
  - mem_ack and the timeout in the same cycle: ack wins, err stays 0.
- Latency:
  - Op accepted at edge N; mem_req high from cycle N+1.
  - Ack sampled at edge M ≥ N+1 → stall low and wb_write high in cycle M+1.
  - Minimum occupancy is 1 REQ cycle.
- Back-to-back: a new op_valid in cycle M+1 is accepted at edge M+1, so a writeback pulse and the next request may overlap.
- wb_reg/wb_data hold their last values when wb_write=0.
- err and wb_write are never both high.
- No address or data arithmetic; all widths pass through unchanged. Register index 0 is not special.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with op_valid=1 → all outputs 0, no mem_req.
- Load, ack after 3 cycles: op_addr=0x0040, op_dest=2, mem_rdata=0xBEEF → mem_req high for exactly 3 cycles, then wb_write pulse with wb_reg=2, wb_data=0xBEEF, and stall falls the same cycle.
- Store: op_addr=0x0010, op_wdata=0x1234, ack on first REQ cycle → mem_we=1, mem_addr=0x0010, mem_wdata=0x1234 for 1 cycle; wb_write stays 0.
- Timeout with TIMEOUT=4 and no ack → mem_req high 4 cycles, then err pulse, no wb_write, IDLE. Repeat with ack exactly on the 4th cycle → writeback occurs and err=0.
- Back-to-back: load then store with op_valid held continuously → second op accepted the cycle after the first ack, during the first load's wb_write pulse. Spurious mem_ack in IDLE is ignored.
- rst_n=0 during REQ → mem_req 0 next cycle, no wb_write, no err; the following op is handled normally.
